// File: rtl/video_tx_timing_engine.sv
// Raster timing engine for the LCD/TFT panel path: counters, start/stop FSM,
// 2-stage pixel pipeline with RGB565 expansion. Optional colour bars: VIDEO_TX_TESTPAT_EN.
module video_tx_timing_engine #(
  parameter int pVHA       = 480,
  parameter int pVHF       = 8,
  parameter int pVHS       = 10,
  parameter int pVHB       = 43,
  parameter int pVVA       = 272,
  parameter int pVVF       = 12,
  parameter int pVVS       = 10,
  parameter int pVVB       = 4,
  parameter bit pHSPol     = 1'b0,
  parameter bit pVSPol     = 1'b0,
  parameter int pChBits    = 8,
  parameter int pFrameCntW = 16
) (
  input  logic                  iVCLK,
  input  logic                  inVRST,
  input  logic                  iEnable,
  input  logic [15:0]           iRd,
  input  logic                  iEmp,
  output logic                  oRe,
  input  logic                  iUnderrunClr,
`ifdef VIDEO_TX_TESTPAT_EN
  input  logic                  iTestPat,
`endif
  output logic [pChBits-1:0]    oVIDEO_R,
  output logic [pChBits-1:0]    oVIDEO_G,
  output logic [pChBits-1:0]    oVIDEO_B,
  output logic                  oVIDEO_HS,
  output logic                  oVIDEO_VS,
  output logic                  oVIDEO_DE,
  output logic                  oFS,
  output logic                  oUnderrun,
  output logic [pFrameCntW-1:0] oFrameCnt
);

  localparam int HTOT = pVHA + pVHF + pVHS + pVHB;
  localparam int VTOT = pVVA + pVVF + pVVS + pVVB;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);

  localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(pVHA);
  localparam logic [HW-1:0] H_SS   = HW'(pVHA + pVHF);
  localparam logic [HW-1:0] H_SE   = HW'(pVHA + pVHF + pVHS);
  localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(pVVA);
  localparam logic [VW-1:0] V_SS   = VW'(pVVA + pVVF);
  localparam logic [VW-1:0] V_SE   = VW'(pVVA + pVVF + pVVS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

  function automatic logic [pChBits-1:0] f_exp5(input logic [4:0] c);
    logic [9:0] t;
    t = {c, c};
    return t[9 -: pChBits];
  endfunction

  function automatic logic [pChBits-1:0] f_exp6(input logic [5:0] c);
    logic [11:0] t;
    t = {c, c};
    return t[11 -: pChBits];
  endfunction

  state_t                r_state;
  logic [HW-1:0]         r_h_p0;
  logic [VW-1:0]         r_v_p0;
  logic [pFrameCntW-1:0] r_frame_cnt;

  logic w_run, w_frame_end, w_de_p0, w_hs_p0, w_vs_p0, w_fs_p0, w_tp_p0;

  assign w_run       = (r_state != ST_IDLE);
  assign w_frame_end = w_run && (r_h_p0 == H_LAST) && (r_v_p0 == V_LAST);
  assign w_de_p0     = w_run && (r_h_p0 < H_ACT) && (r_v_p0 < V_ACT);
  assign w_hs_p0     = w_run && (r_h_p0 >= H_SS) && (r_h_p0 < H_SE);
  assign w_vs_p0     = w_run && (r_v_p0 >= V_SS) && (r_v_p0 < V_SE);
  assign w_fs_p0     = w_run && (r_h_p0 == '0) && (r_v_p0 == '0);
`ifdef VIDEO_TX_TESTPAT_EN
  assign w_tp_p0     = iTestPat;
`else
  assign w_tp_p0     = 1'b0;
`endif
  assign oRe         = w_de_p0 && !w_tp_p0;
  assign oFrameCnt   = r_frame_cnt;

  // Stage 0: FSM and raster counters. A dropped enable only takes effect at frame end.
  always_ff @(posedge iVCLK) begin
    if (!inVRST) begin
      r_state     <= ST_IDLE;
      r_h_p0      <= '0;
      r_v_p0      <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_h_p0 <= '0;
          r_v_p0 <= '0;
          if (iEnable) r_state <= ST_RUN;
        end
        ST_RUN, ST_STOP: begin
          if (r_h_p0 == H_LAST) begin
            r_h_p0 <= '0;
            r_v_p0 <= (r_v_p0 == V_LAST) ? '0 : r_v_p0 + 1'b1;
          end else begin
            r_h_p0 <= r_h_p0 + 1'b1;
          end
          if (w_frame_end) r_frame_cnt <= r_frame_cnt + 1'b1;
          if (iEnable)          r_state <= ST_RUN;
          else if (w_frame_end) r_state <= ST_IDLE;
          else                  r_state <= ST_STOP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic r_de_p1, r_hs_p1, r_vs_p1, r_fs_p1, r_re_p1, r_emp_p1;
`ifdef VIDEO_TX_TESTPAT_EN
  logic          r_tp_p1;
  logic [HW-1:0] r_h_p1;
`endif

  // Stage 1: pixel from the FIFO lands; controls and empty flag follow the read.
  always_ff @(posedge iVCLK) begin
    if (!inVRST) begin
      r_de_p1  <= 1'b0;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
      r_fs_p1  <= 1'b0;
      r_re_p1  <= 1'b0;
      r_emp_p1 <= 1'b0;
`ifdef VIDEO_TX_TESTPAT_EN
      r_tp_p1  <= 1'b0;
      r_h_p1   <= '0;
`endif
    end else begin
      r_de_p1  <= w_de_p0;
      r_hs_p1  <= w_hs_p0;
      r_vs_p1  <= w_vs_p0;
      r_fs_p1  <= w_fs_p0;
      r_re_p1  <= oRe;
      r_emp_p1 <= iEmp;
`ifdef VIDEO_TX_TESTPAT_EN
      r_tp_p1  <= iTestPat;
      r_h_p1   <= r_h_p0;
`endif
    end
  end

`ifdef VIDEO_TX_TESTPAT_EN
  localparam int            BARW_I = (pVHA / 8 > 0) ? pVHA / 8 : 1;
  localparam logic [HW-1:0] BARW   = HW'(BARW_I);

  function automatic logic [15:0] f_bar(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  logic [HW-1:0] w_bar_q_p1;
  logic [2:0]    w_bar_p1;
  assign w_bar_q_p1 = r_h_p1 / BARW;
  // Leftover columns when pVHA is not a multiple of 8 stay in the last (black) bar.
  assign w_bar_p1   = (w_bar_q_p1 > HW'(7)) ? 3'd7 : w_bar_q_p1[2:0];
`endif

  logic        w_under_p1;
  logic [15:0] w_pix_p1;
  assign w_under_p1 = r_re_p1 && r_emp_p1;

  always_comb begin
    w_pix_p1 = 16'h0000;
    if (r_de_p1) begin
`ifdef VIDEO_TX_TESTPAT_EN
      if (r_tp_p1)        w_pix_p1 = f_bar(w_bar_p1);
      else if (!r_emp_p1) w_pix_p1 = iRd;
`else
      if (!r_emp_p1)      w_pix_p1 = iRd;
`endif
    end
  end

  // Stage 2: pin registers, aligned two cycles after the counters.
  always_ff @(posedge iVCLK) begin
    if (!inVRST) begin
      oVIDEO_R  <= '0;
      oVIDEO_G  <= '0;
      oVIDEO_B  <= '0;
      oVIDEO_DE <= 1'b0;
      oVIDEO_HS <= ~pHSPol;
      oVIDEO_VS <= ~pVSPol;
      oFS       <= 1'b0;
      oUnderrun <= 1'b0;
    end else begin
      oVIDEO_R  <= f_exp5(w_pix_p1[15:11]);
      oVIDEO_G  <= f_exp6(w_pix_p1[10:5]);
      oVIDEO_B  <= f_exp5(w_pix_p1[4:0]);
      oVIDEO_DE <= r_de_p1;
      oVIDEO_HS <= r_hs_p1 ? pHSPol : ~pHSPol;
      oVIDEO_VS <= r_vs_p1 ? pVSPol : ~pVSPol;
      oFS       <= r_fs_p1;
      if (w_under_p1)        oUnderrun <= 1'b1;
      else if (iUnderrunClr) oUnderrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_tx_timing_engine.sv
// Directed bench for video_tx_timing_engine on a 12x7 raster (84 clocks per frame).
module tb_video_tx_timing_engine;

  logic        iVCLK = 1'b0;
  logic        inVRST, iEnable, iEmp, oRe, iUnderrunClr;
  logic [15:0] iRd;
  logic        iTestPat;
  logic [7:0]  oVIDEO_R, oVIDEO_G, oVIDEO_B;
  logic        oVIDEO_HS, oVIDEO_VS, oVIDEO_DE, oFS, oUnderrun;
  logic [15:0] oFrameCnt;

  always #5 iVCLK = ~iVCLK;

  video_tx_timing_engine #(
    .pVHA(8), .pVHF(1), .pVHS(2), .pVHB(1),
    .pVVA(4), .pVVF(1), .pVVS(1), .pVVB(1),
    .pHSPol(1'b0), .pVSPol(1'b0), .pChBits(8), .pFrameCntW(16)
  ) dut (
    .iVCLK(iVCLK), .inVRST(inVRST), .iEnable(iEnable), .iRd(iRd), .iEmp(iEmp),
    .oRe(oRe), .iUnderrunClr(iUnderrunClr),
`ifdef VIDEO_TX_TESTPAT_EN
    .iTestPat(iTestPat),
`endif
    .oVIDEO_R(oVIDEO_R), .oVIDEO_G(oVIDEO_G), .oVIDEO_B(oVIDEO_B),
    .oVIDEO_HS(oVIDEO_HS), .oVIDEO_VS(oVIDEO_VS), .oVIDEO_DE(oVIDEO_DE),
    .oFS(oFS), .oUnderrun(oUnderrun), .oFrameCnt(oFrameCnt)
  );

  int n_chk = 0;
  int n_err = 0;
  int run_start = 0;
  int run_stop  = 1 << 30;
  int tp_k      = 1 << 30;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {DE, HS level, VS level, FS} produced by the counters at cycle x.
  function automatic logic [3:0] raw(input int x);
    int t, h, v;
    logic de, hs, vs, fs;
    if (x < run_start || x >= run_stop) return 4'b0110;
    t  = x - run_start;
    h  = t % 12;
    v  = (t / 12) % 7;
    de = (h < 8) && (v < 4);
    hs = !((h >= 9) && (h < 11));
    vs = (v != 5);
    fs = (h == 0) && (v == 0);
    return {de, hs, vs, fs};
  endfunction

  function automatic logic [23:0] bar_rgb(input int h);
    case (h)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic step();
    @(posedge iVCLK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rgb"}, {oVIDEO_R, oVIDEO_G, oVIDEO_B}, 24'h0);
    chk({tag, " sync"}, {oVIDEO_DE, oVIDEO_HS, oVIDEO_VS, oFS}, 4'b0110);
    chk({tag, " re"}, oRe, 1'b0);
    chk({tag, " unr"}, oUnderrun, 1'b0);
    chk({tag, " fcnt"}, oFrameCnt, 16'd0);
  endtask

  initial begin
    logic [3:0]  s, r0;
    logic [23:0] cur_exp, e_rgb;
    logic        e_unr;
    inVRST = 1'b0; iEnable = 1'b0; iEmp = 1'b0; iUnderrunClr = 1'b0;
    iRd = 16'hF800; iTestPat = 1'b0;
    cur_exp = 24'hFF0000;
    e_unr   = 1'b0;

    step(); step(); step();
    chk_reset_state("por");
    inVRST = 1'b1;
    step();
    chk_reset_state("idle");
    iEnable = 1'b1;
    step();

    for (int k = 0; k <= 370; k++) begin
      case (k)
        84:  begin iRd = 16'h0841; cur_exp = 24'h080808; end
        92:  iEmp = 1'b1;
        93:  iEmp = 1'b0;
        98:  iEmp = 1'b1;
        99:  iEmp = 1'b0;
        110: iUnderrunClr = 1'b1;
        111: iUnderrunClr = 1'b0;
        122: iEmp = 1'b1;
        123: begin iEmp = 1'b0; iUnderrunClr = 1'b1; end
        124: iUnderrunClr = 1'b0;
        180: iEnable = 1'b0;
        190: iEnable = 1'b1;
        200: begin iEnable = 1'b0; run_stop = 252; end
        270: begin iEnable = 1'b1; run_start = 271; run_stop = 1 << 30; end
        287: inVRST = 1'b0;
        289: begin inVRST = 1'b1; run_start = 290; end
`ifdef VIDEO_TX_TESTPAT_EN
        340: begin iTestPat = 1'b1; tp_k = 340; end
`endif
        default: ;
      endcase

      if (k == 100 || k == 124) e_unr = 1'b1;
      if (k == 111 || k == 288) e_unr = 1'b0;

      if (k == 288 || k == 289) begin
        chk_reset_state($sformatf("rst@%0d", k));
      end else begin
        s  = raw(k - 2);
        r0 = raw(k);
        chk($sformatf("sync@%0d", k), {oVIDEO_DE, oVIDEO_HS, oVIDEO_VS, oFS}, s);
        chk($sformatf("re@%0d", k), oRe, r0[3] && (k < tp_k));
        e_rgb = 24'h0;
        if (s[3]) begin
          if (k == 100 || k == 124) e_rgb = 24'h0;
          else if (k - 2 >= tp_k)   e_rgb = bar_rgb((k - 2 - run_start) % 12);
          else                      e_rgb = cur_exp;
        end
        chk($sformatf("rgb@%0d", k), {oVIDEO_R, oVIDEO_G, oVIDEO_B}, e_rgb);
        chk($sformatf("unr@%0d", k), oUnderrun, e_unr);
      end

      case (k)
        83:  chk("fcnt@83", oFrameCnt, 16'd0);
        84:  chk("fcnt@84", oFrameCnt, 16'd1);
        168: chk("fcnt@168", oFrameCnt, 16'd2);
        252: chk("fcnt@252", oFrameCnt, 16'd3);
        270: chk("fcnt@270", oFrameCnt, 16'd3);
        default: ;
      endcase

      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
